// File: rtl/cpu_pkg.sv
// Shared opcode values, op-class encoding and execute-sequencer state encoding for the 32-bit CPU.
package cpu_pkg;

  localparam int unsigned OPC_W = 6;

  localparam logic [OPC_W-1:0] OP_ADD   = 6'd1;
  localparam logic [OPC_W-1:0] OP_SUB   = 6'd2;
  localparam logic [OPC_W-1:0] OP_STORE = 6'd3;
  localparam logic [OPC_W-1:0] OP_LOAD  = 6'd4;
  localparam logic [OPC_W-1:0] OP_MOVE  = 6'd5;
  localparam logic [OPC_W-1:0] OP_SGE   = 6'd6;
  localparam logic [OPC_W-1:0] OP_SLE   = 6'd7;
  localparam logic [OPC_W-1:0] OP_SGT   = 6'd8;
  localparam logic [OPC_W-1:0] OP_SLT   = 6'd9;
  localparam logic [OPC_W-1:0] OP_SEQ   = 6'd10;
  localparam logic [OPC_W-1:0] OP_SNE   = 6'd11;
  localparam logic [OPC_W-1:0] OP_AND   = 6'd12;
  localparam logic [OPC_W-1:0] OP_OR    = 6'd13;
  localparam logic [OPC_W-1:0] OP_XOR   = 6'd14;
  localparam logic [OPC_W-1:0] OP_NOT   = 6'd15;
  localparam logic [OPC_W-1:0] OP_MOVEI = 6'd16;
  localparam logic [OPC_W-1:0] OP_SLI   = 6'd17;
  localparam logic [OPC_W-1:0] OP_SRI   = 6'd18;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'd19;
  localparam logic [OPC_W-1:0] OP_SUBI  = 6'd20;
  localparam logic [OPC_W-1:0] OP_ADDF  = 6'd23;
  localparam logic [OPC_W-1:0] OP_MULF  = 6'd24;

  typedef enum logic [2:0] {
    ClsReg,
    ClsUnary,
    ClsImm,
    ClsLoad,
    ClsStore,
    ClsFp,
    ClsIllegal
  } op_class_e;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StMemWait,
    StFpWait,
    StWb,
    StErr
  } state_e;

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode classifier: op class plus operand-B select. Shared with the decode stage.
module op_class_decode
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output op_class_e        op_class,
  output logic             opb_sel
);

  always_comb begin
    op_class = ClsIllegal;
    opb_sel  = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_SGE, OP_SLE, OP_SGT, OP_SLT, OP_SEQ, OP_SNE,
      OP_AND, OP_OR, OP_XOR:                     op_class = ClsReg;
      OP_MOVE, OP_NOT:                           op_class = ClsUnary;
      OP_MOVEI, OP_SLI, OP_SRI, OP_ADDI, OP_SUBI: begin
        op_class = ClsImm;
        opb_sel  = 1'b1;
      end
      OP_LOAD: begin
        op_class = ClsLoad;
        opb_sel  = 1'b1;
      end
      OP_STORE: begin
        op_class = ClsStore;
        opb_sel  = 1'b1;
      end
      OP_ADDF, OP_MULF:                          op_class = ClsFp;
      default:                                   op_class = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/exec_seq_ctrl.sv
// Execute-stage sequencer: accepts one decoded instruction and steps it through ALU, memory,
// FP and write-back. Define MEM_TIMEOUT_EN to abort memory waits after MEM_TO_CYCLES cycles.
module exec_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TO_CYCLES = 16,
  parameter int unsigned TO_CNT_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [OPC_W-1:0] opcode,
  output logic             opb_sel,
  output logic             alu_en,
  output logic [OPC_W-1:0] alu_op,
  output logic             mem_re,
  output logic             mem_we,
  input  logic             mem_ack,
  output logic             fp_start,
  input  logic             fp_done,
  output logic             reg_we,
  output logic             illegal_op,
  output logic             mem_err,
  output logic             busy
);

  if ((2 ** TO_CNT_W) <= MEM_TO_CYCLES) begin : g_bad_to_cnt_w
    $error("TO_CNT_W too narrow for MEM_TO_CYCLES");
  end

  state_e          state_q, state_d;
  op_class_e       cls_q, dec_cls;
  logic [OPC_W-1:0] alu_op_q;
  logic            opb_sel_q, dec_opb;
  logic            accept;

  op_class_decode u_decode (
    .opcode   (opcode),
    .op_class (dec_cls),
    .opb_sel  (dec_opb)
  );

  assign accept = instr_valid && (state_q == StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cls_q     <= ClsIllegal;
      alu_op_q  <= '0;
      opb_sel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cls_q     <= dec_cls;
        alu_op_q  <= opcode;
        opb_sel_q <= dec_opb;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [TO_CNT_W-1:0] to_cnt_q;
  logic                timeout;

  // Held at zero outside MEM_WAIT, so every entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (reset || (state_q != StMemWait)) begin
      to_cnt_q <= '0;
    end else if (!mem_ack) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q == StMemWait) && !mem_ack &&
                   (to_cnt_q == TO_CNT_W'(MEM_TO_CYCLES - 1));
`endif

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    alu_en      = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    fp_start    = 1'b0;
    reg_we      = 1'b0;
    illegal_op  = 1'b0;
    mem_err     = 1'b0;
    case (state_q)
      StIdle: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = (dec_cls == ClsIllegal) ? StErr : StExec;
      end
      StExec: begin
        alu_en = 1'b1;
        case (cls_q)
          ClsLoad, ClsStore: state_d = StMemWait;
          ClsFp: begin
            fp_start = 1'b1;
            state_d  = StFpWait;
          end
          default:           state_d = StWb;
        endcase
      end
      StMemWait: begin
        mem_re = (cls_q == ClsLoad);
        mem_we = (cls_q == ClsStore);
        if (mem_ack) begin
          state_d = (cls_q == ClsLoad) ? StWb : StIdle;
        end
`ifdef MEM_TIMEOUT_EN
        else if (timeout) begin
          mem_err = 1'b1;
          state_d = StIdle;
        end
`endif
      end
      StFpWait: if (fp_done) state_d = StWb;
      StWb: begin
        reg_we  = 1'b1;
        state_d = StIdle;
      end
      StErr: begin
        illegal_op = 1'b1;
        state_d    = StIdle;
      end
      default:   state_d = StIdle;
    endcase
  end

  assign alu_op  = alu_op_q;
  assign opb_sel = opb_sel_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_exec_seq_ctrl.sv
// Scoreboard bench for exec_seq_ctrl: driver pushes per-instruction expectations, monitor checks.
module tb_exec_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [5:0] opcode = '0;
  logic       opb_sel, alu_en, mem_re, mem_we, fp_start, reg_we, illegal_op, mem_err, busy;
  logic [5:0] alu_op;
  logic       mem_ack = 1'b0;
  logic       fp_done = 1'b0;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  exec_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .opb_sel     (opb_sel),
    .alu_en      (alu_en),
    .alu_op      (alu_op),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_ack     (mem_ack),
    .fp_start    (fp_start),
    .fp_done     (fp_done),
    .reg_we      (reg_we),
    .illegal_op  (illegal_op),
    .mem_err     (mem_err),
    .busy        (busy)
  );

  typedef struct {
    logic [5:0] op;
    logic       opb;
    int         busy_cyc;
    int         alu;
    int         rwe;
    int         mre;
    int         mwe;
    int         fps;
    int         ill;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: class rules and latency table written straight from the opcode map.
  function automatic exp_t model(input logic [5:0] op, input int n);
    exp_t e;
    bit is_reg, is_un, is_imm, is_ld, is_st, is_fp;
    is_reg = op inside {6'd1, 6'd2, [6'd6:6'd14]};
    is_un  = op inside {6'd5, 6'd15};
    is_imm = op inside {[6'd16:6'd20]};
    is_ld  = (op == 6'd4);
    is_st  = (op == 6'd3);
    is_fp  = op inside {6'd23, 6'd24};
    e.op  = op;
    e.opb = is_imm || is_ld || is_st;
    e.alu = 0; e.rwe = 0; e.mre = 0; e.mwe = 0; e.fps = 0; e.ill = 0;
    if (is_reg || is_un || is_imm) begin
      e.busy_cyc = 3 - 1; e.alu = 1; e.rwe = 1;
    end else if (is_ld) begin
      e.busy_cyc = 3 + n - 1; e.alu = 1; e.rwe = 1; e.mre = n;
    end else if (is_st) begin
      e.busy_cyc = 2 + n - 1; e.alu = 1; e.mwe = n;
    end else if (is_fp) begin
      e.busy_cyc = 3 + n - 1; e.alu = 1; e.rwe = 1; e.fps = 1;
    end else begin
      e.busy_cyc = 2 - 1; e.ill = 1;
    end
    return e;
  endfunction

  // Monitor: accumulates activity over each busy window and compares at its end.
  int  c_busy, c_alu, c_rwe, c_mre, c_mwe, c_fps, c_ill, c_err;
  bit  in_txn = 1'b0;
  bit  unstable;
  always @(negedge clk) begin
    if (reset || !mon_en) begin
      in_txn = 1'b0;
    end else if (busy) begin
      if (!in_txn) begin
        in_txn = 1'b1;
        c_busy = 0; c_alu = 0; c_rwe = 0; c_mre = 0; c_mwe = 0; c_fps = 0; c_ill = 0;
        c_err = 0; unstable = 1'b0;
      end
      c_busy++;
      c_alu += int'(alu_en); c_rwe += int'(reg_we); c_mre += int'(mem_re);
      c_mwe += int'(mem_we); c_fps += int'(fp_start); c_ill += int'(illegal_op);
      c_err += int'(mem_err);
      if (exp_q.size() == 0 || alu_op !== exp_q[0].op || opb_sel !== exp_q[0].opb)
        unstable = 1'b1;
    end else begin
      if (in_txn) begin
        exp_t e;
        in_txn = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_txn", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("op%0d_busy_cycles", e.op), c_busy, e.busy_cyc);
          chk($sformatf("op%0d_alu_en", e.op), c_alu, e.alu);
          chk($sformatf("op%0d_reg_we", e.op), c_rwe, e.rwe);
          chk($sformatf("op%0d_mem_re", e.op), c_mre, e.mre);
          chk($sformatf("op%0d_mem_we", e.op), c_mwe, e.mwe);
          chk($sformatf("op%0d_fp_start", e.op), c_fps, e.fps);
          chk($sformatf("op%0d_illegal", e.op), c_ill, e.ill);
          chk($sformatf("op%0d_mem_err", e.op), c_err, 0);
          chk($sformatf("op%0d_opsel_stable", e.op), int'(unstable), 0);
        end
      end
      chk("idle_quiet", int'({alu_en, reg_we, mem_re, mem_we, fp_start, illegal_op, mem_err}),
          0);
    end
  end

  task automatic wait_cond_negedge(input int sel, input string name);
    int k = 0;
    while (k < 50) begin
      @(negedge clk);
      if ((sel == 0 && (mem_re || mem_we)) || (sel == 1 && fp_start) ||
          (sel == 2 && instr_ready)) return;
      k++;
    end
    chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic run_instr(input logic [5:0] op, input int n);
    exp_t e;
    e = model(op, n);
    exp_q.push_back(e);
    opcode      = op;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    opcode      = 6'($urandom);
    if (e.mre > 0 || e.mwe > 0) begin
      if (!(mem_re || mem_we)) wait_cond_negedge(0, "mem_req");
      for (int k = 1; k < n; k++) @(negedge clk);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
    end else if (e.fps > 0) begin
      if (!fp_start) wait_cond_negedge(1, "fp_start");
      @(negedge clk);
      for (int k = 1; k < n; k++) @(negedge clk);
      fp_done = 1'b1;
      @(negedge clk);
      fp_done = 1'b0;
    end
    if (!instr_ready) wait_cond_negedge(2, "ready");
    // Idle gap with stray handshakes that must be ignored.
    for (int g = int'($urandom_range(2)); g > 0; g--) begin
      mem_ack = 1'($urandom);
      fp_done = 1'($urandom);
      @(negedge clk);
      mem_ack = 1'b0;
      fp_done = 1'b0;
    end
  endtask

  logic [5:0] dir_ops[8] = '{6'd1, 6'd19, 6'd4, 6'd3, 6'd24, 6'd0, 6'd21, 6'd63};
  int         dir_n[8]   = '{1, 1, 4, 1, 5, 1, 1, 1};

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_ready", int'(instr_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_alu_op", int'(alu_op), 0);
    chk("reset_opb_sel", int'(opb_sel), 0);
    fp_done = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    fp_done = 1'b0;
    mem_ack = 1'b0;
    chk("stray_fp_done_idle", int'(busy), 0);
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) run_instr(dir_ops[i], dir_n[i]);
    for (int i = 0; i < 60; i++) begin
      logic [5:0] op;
      op = ($urandom_range(3) == 0) ? 6'($urandom) : 6'($urandom_range(24, 1));
      run_instr(op, int'($urandom_range(6, 1)));
    end
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    // Reset while a LOAD is waiting on memory.
    opcode      = 6'd4;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    wait_cond_negedge(0, "rst_load_req");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_mem_re", int'(mem_re), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_ready", int'(instr_ready), 1);
    chk("rst_mid_alu_op", int'(alu_op), 0);
    begin
      int rw = 0;
      for (int k = 0; k < 5; k++) begin
        rw += int'(reg_we);
        @(negedge clk);
      end
      chk("rst_mid_no_reg_we", rw, 0);
    end

`ifdef MEM_TIMEOUT_EN
    begin
      int re_cnt = 0, err_cnt = 0, rw = 0;
      opcode      = 6'd4;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        re_cnt  += int'(mem_re);
        err_cnt += int'(mem_err);
        rw      += int'(reg_we);
      end
      chk("to_mem_re_cycles", re_cnt, 16);
      chk("to_mem_err_pulse", err_cnt, 1);
      chk("to_no_reg_we", rw, 0);
      chk("to_ready", int'(instr_ready), 1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
